// File: rtl/mcpu_pkg.sv
// +----------------------------------------------------------------------+
// | mcpu_pkg : shared opcode, state and control-field codes for mcpu_ctrl |
// | Optional: MCPU_BNE_EN adds the bne opcode. Rev 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
`ifdef MCPU_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EXEC   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_ERR      = 4'd13
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] DST_RD  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mcpu_wait_timer.sv
// +----------------------------------------------------------------------+
// | mcpu_wait_timer : memory-wait counter, expired at all-ones. Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module mcpu_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/mcpu_ctrl.sv
// +----------------------------------------------------------------------+
// | mcpu_ctrl : multi-cycle MIPS control FSM with memory wait/timeout     |
// | Optional: MCPU_BNE_EN adds bne decode and branch_ne_o. Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module mcpu_ctrl import mcpu_pkg::*; #(
  parameter int WAIT_W  = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic [1:0]         pc_source_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [1:0]         ext_op_o,
  output logic               illegal_o,
`ifdef MCPU_BNE_EN
  output logic               branch_ne_o,
`endif
  output logic               err_o
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [2:0] alu_op_c;
  logic       wait_st, expired;

  assign wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  // Counter sits at zero outside wait states, so every entry starts fresh.
  mcpu_wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!wait_st || mem_ready_i),
    .en_i      (wait_st && !mem_ready_i),
    .expired_o (expired)
  );

  assign op_d     = (state_q == ST_DECODE) ? opcode_i : op_q;
  assign alu_op_o = ALUOP_W'(alu_op_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = PCS_ALU;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = DST_RD;
    mem_to_reg_o    = M2R_ALUOUT;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_B;
    alu_op_c        = ALU_ADD;
    ext_op_o        = EXT_ZERO;
    illegal_o       = 1'b0;
    err_o           = 1'b0;
`ifdef MCPU_BNE_EN
    branch_ne_o     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        alu_src_b_o = SRCB_IMMSH;
        ext_op_o    = EXT_SIGN;
        case (opcode_i)
          OP_RTYPE:              state_d = ST_R_EXEC;
          OP_LW, OP_SW:          state_d = ST_MEM_ADDR;
          OP_ORI, OP_ADDI, OP_LUI: state_d = ST_I_EXEC;
          OP_BEQ:                state_d = ST_BRANCH;
`ifdef MCPU_BNE_EN
          OP_BNE:                state_d = ST_BRANCH;
`endif
          OP_J, OP_JAL:          state_d = ST_JUMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        ext_op_o    = EXT_SIGN;
        state_d     = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = ST_MEM_WB;
        else if (expired) state_d = ST_ERR;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = DST_RT;
        mem_to_reg_o = M2R_MDR;
        state_d      = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) state_d = ST_FETCH;
        else if (expired) state_d = ST_ERR;
      end
      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_c    = ALU_FUNCT;
        state_d     = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_o = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        case (op_q)
          OP_ORI: begin alu_op_c = ALU_OR;    ext_op_o = EXT_ZERO; end
          OP_LUI: begin alu_op_c = ALU_PASSB; ext_op_o = EXT_LUI;  end
          default: begin alu_op_c = ALU_ADD;  ext_op_o = EXT_SIGN; end
        endcase
        state_d = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = DST_RT;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_c        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCS_ALUOUT;
`ifdef MCPU_BNE_EN
        branch_ne_o     = (op_q == OP_BNE);
`endif
        state_d         = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCS_JUMP;
        // PC was already advanced in FETCH, so it is the link value for jal.
        if (op_q == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = DST_R31;
          mem_to_reg_o = M2R_PC;
        end
        state_d = ST_FETCH;
      end
      ST_ERR: err_o = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
